// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ALU decode stage, the execution unit and writeback.
// The requester/consumer side uses master; the execution unit uses slave.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [10:0]     op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            err;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution unit for the one-hot ALU op code: single-cycle add/sub/logic/compare,
// bit-serial shifts, and a result held in DONE until writeback accepts it.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input logic          clk,
    input logic          rst,
    alu_exec_unit_if.slave bus
);

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 5;
    localparam int OP_SRL  = 6;
    localparam int OP_SRA  = 7;
    localparam int OP_SLT  = 8;
    localparam int OP_SLTU = 9;
    localparam int OP_RSVD = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_e;

    state_e          state_q, state_d;
    shift_e          kind_q, kind_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q, err_d;

    logic            op_legal;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifted;
    shift_e          req_kind;

    assign op_legal = $onehot(bus.op) && !bus.op[OP_RSVD];
    assign is_shift = bus.op[OP_SLL] | bus.op[OP_SRL] | bus.op[OP_SRA];
    assign shamt    = bus.src2[SHW-1:0];
    assign req_kind = bus.op[OP_SLL] ? SH_SLL : (bus.op[OP_SRL] ? SH_SRL : SH_SRA);

    // Single-cycle datapath; only meaningful when op is a legal non-shift code.
    always_comb begin
        alu_res = '0;
        case (1'b1)
            bus.op[OP_ADD]:  alu_res = bus.src1 + bus.src2;
            bus.op[OP_SUB]:  alu_res = bus.src1 - bus.src2;
            bus.op[OP_AND]:  alu_res = bus.src1 & bus.src2;
            bus.op[OP_OR]:   alu_res = bus.src1 | bus.src2;
            bus.op[OP_XOR]:  alu_res = bus.src1 ^ bus.src2;
            bus.op[OP_SLT]:  alu_res = XLEN'($signed(bus.src1) < $signed(bus.src2));
            bus.op[OP_SLTU]: alu_res = XLEN'(bus.src1 < bus.src2);
            default:         alu_res = '0;
        endcase
    end

    always_comb begin
        shifted = result_q;
        case (kind_q)
            SH_SLL:  shifted = {result_q[XLEN-2:0], 1'b0};
            SH_SRL:  shifted = {1'b0, result_q[XLEN-1:1]};
            SH_SRA:  shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: shifted = result_q;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!op_legal) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (is_shift) begin
                        result_d = bus.src1;
                        err_d    = 1'b0;
                        kind_d   = req_kind;
                        cnt_d    = shamt;
                        state_d  = (shamt == '0) ? DONE : SHIFT;
                    end else begin
                        result_d = alu_res;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end

            SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= SH_SLL;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, backpressure,
// illegal ops and reset in SHIFT/DONE.
module tb_alu_exec_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, keep in_valid high with junk while busy, measure latency,
    // check the held result, then retire it.
    task automatic do_op(input string tag, input logic [10:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.src1     = a;
        bus.src2     = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.op   = 11'h002;
        bus.src1 = $urandom;
        bus.src2 = $urandom;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.src1 = $urandom;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " err"}, 32'(bus.err), 32'(exp_err));
        check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " retire"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", bus.result, 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        do_op("add",  11'h001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1);
        do_op("slt",  11'h100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        do_op("sltu", 11'h200, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        do_op("and",  11'h004, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
        do_op("or",   11'h008, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1);
        do_op("xor",  11'h010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1);
        do_op("sra4", 11'h080, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5);
        do_op("srl4", 11'h040, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 5);
        do_op("sll31", 11'h020, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);
        do_op("sra0", 11'h080, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1);
        do_op("sll0", 11'h020, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, 1'b0, 1);
        do_op("ill3", 11'h003, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1);
        do_op("ill400", 11'h400, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1);
        do_op("ill0", 11'h000, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1);
        do_op("add after ill", 11'h001, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1);

        // Backpressure: sub held in DONE for 10 cycles while a new request is offered.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 11'h002;
        bus.src1     = 32'd5;
        bus.src2     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.op   = 11'h001;
        bus.src1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp result", bus.result, 32'hFFFF_FFFE);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);

        // Reset five cycles into a 20-bit sll; the shift result must never appear.
        bus.in_valid = 1'b1;
        bus.op       = 11'h020;
        bus.src1     = 32'h0000_0003;
        bus.src2     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid-shift rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid-shift rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid-shift rst result", bus.result, 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mid-shift no stale result", 32'(seen), 32'd0);

        // Reset while an illegal-op response waits in DONE.
        bus.in_valid = 1'b1;
        bus.op       = 11'h400;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("done pre-rst err", 32'(bus.err), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("done rst out_valid", 32'(bus.out_valid), 32'd0);
        check("done rst err", 32'(bus.err), 32'd0);

        // out_ready held high before a request has no effect on the idle unit.
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("early out_ready out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        do_op("final sub", 11'h002, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
